// File: rtl/arbitro_rr4.sv
// Four-way round-robin arbiter with hold-until-release grants, hold timeout and a guard idle cycle.
// Latency: req -> grant 1 cycle, all outputs registered; owner holds until done, request drop or timeout.
module arbitro_rr4 #(
    parameter int HOLD_W   = 4,
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic       gnt_valid,
    output logic       gnt_s1,
    output logic       gnt_s0,
    output logic [3:0] gnt,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state_q, state_d;
    logic [1:0]          sel_q, sel_d;
    logic [1:0]          last_q, last_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                vld_q, vld_d;
    logic [3:0]          gnt_q, gnt_d;
    logic                to_q, to_d;

    logic [1:0]          win;
    logic [1:0]          cand;
    logic                found;
    logic                hold_hit;

    // Search starts just after the last owner, so the last owner ranks lowest.
    always_comb begin
        win   = last_q;
        cand  = last_q;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    assign hold_hit = (MAX_HOLD != 0) && (hold_q == HOLD_W'(MAX_HOLD));

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        hold_d  = hold_q;
        vld_d   = vld_q;
        gnt_d   = gnt_q;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                vld_d = 1'b0;
                gnt_d = 4'b0000;
                if (req != 4'b0000) begin
                    state_d = GRANT;
                    sel_d   = win;
                    vld_d   = 1'b1;
                    gnt_d   = 4'b0001 << win;
                    hold_d  = HOLD_W'(1);
                end
            end
            GRANT: begin
                // Release always passes through IDLE, giving the decoder its guard cycle.
                if (done || !req[sel_q] || hold_hit) begin
                    state_d = IDLE;
                    vld_d   = 1'b0;
                    gnt_d   = 4'b0000;
                    last_d  = sel_q;
                    hold_d  = '0;
                    to_d    = !done && req[sel_q];
                end else if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 2'b00;
            last_q  <= 2'b11;
            hold_q  <= '0;
            vld_q   <= 1'b0;
            gnt_q   <= 4'b0000;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            vld_q   <= vld_d;
            gnt_q   <= gnt_d;
            to_q    <= to_d;
        end
    end

    assign gnt_valid = vld_q;
    assign gnt_s1    = sel_q[1];
    assign gnt_s0    = sel_q[0];
    assign gnt       = gnt_q;
    assign timeout   = to_q;

endmodule

// File: tb/tb_arbitro_rr4.sv
// Directed bench for arbitro_rr4: per-cycle vector table on the default build,
// plus hand-written timeout/collision sequences on builds with short MAX_HOLD.
module tb_arbitro_rr4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;

    always #5 clk = ~clk;

    logic       v15, s1_15, s0_15, to15;
    logic [3:0] g15;
    logic       v3, s1_3, s0_3, to3;
    logic [3:0] g3;
    logic       v2, s1_2, s0_2, to2;
    logic [3:0] g2;
    logic       v0, s1_0, s0_0, to0;
    logic [3:0] g0;

    arbitro_rr4 #(.HOLD_W(4), .MAX_HOLD(15)) dut (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt_valid(v15), .gnt_s1(s1_15), .gnt_s0(s0_15), .gnt(g15), .timeout(to15));
    arbitro_rr4 #(.HOLD_W(4), .MAX_HOLD(3)) dut3 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt_valid(v3), .gnt_s1(s1_3), .gnt_s0(s0_3), .gnt(g3), .timeout(to3));
    arbitro_rr4 #(.HOLD_W(4), .MAX_HOLD(2)) dut2 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt_valid(v2), .gnt_s1(s1_2), .gnt_s0(s0_2), .gnt(g2), .timeout(to2));
    arbitro_rr4 #(.HOLD_W(4), .MAX_HOLD(0)) dut0 (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt_valid(v0), .gnt_s1(s1_0), .gnt_s0(s0_0), .gnt(g0), .timeout(to0));

    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] req;
        logic       done;
        logic       vld;
        logic [1:0] sel;
        logic [3:0] gnt;
        logic       to;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input string n, input logic r, input logic [3:0] q, input logic d,
                       input logic v, input logic [1:0] s, input logic [3:0] g, input logic t);
        vec_t e;
        e.name = n; e.rst = r; e.req = q; e.done = d;
        e.vld = v; e.sel = s; e.gnt = g; e.to = t;
        tbl.push_back(e);
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 4'b0000; done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int vcnt;
        bit seen;
        logic [3:0] eg;
        logic       et;

        rst = 1'b1; req = 4'b1111; done = 1'b0;

        // Each row: inputs before a rising edge, expected {valid,sel,gnt,timeout} after it.
        add("rst_a",     1, 4'b1111, 0, 0, 2'b00, 4'b0000, 0);
        add("rst_b",     1, 4'b1111, 0, 0, 2'b00, 4'b0000, 0);
        add("post_rst",  0, 4'b0000, 0, 0, 2'b00, 4'b0000, 0);
        add("single_c1", 0, 4'b0100, 0, 1, 2'b10, 4'b0100, 0);
        add("single_c2", 0, 4'b0100, 0, 1, 2'b10, 4'b0100, 0);
        add("single_c3", 0, 4'b0100, 0, 1, 2'b10, 4'b0100, 0);
        add("single_rel",0, 4'b0100, 1, 0, 2'b10, 4'b0000, 0);
        add("single_re", 0, 4'b0100, 0, 1, 2'b10, 4'b0100, 0);
        add("drop_rel",  0, 4'b0000, 0, 0, 2'b10, 4'b0000, 0);
        add("idle_done", 0, 4'b0000, 1, 0, 2'b10, 4'b0000, 0);
        add("rot_rst",   1, 4'b0000, 0, 0, 2'b00, 4'b0000, 0);
        add("rot_g0",    0, 4'b1111, 0, 1, 2'b00, 4'b0001, 0);
        add("rot_i0",    0, 4'b1111, 1, 0, 2'b00, 4'b0000, 0);
        add("rot_g1",    0, 4'b1111, 0, 1, 2'b01, 4'b0010, 0);
        add("rot_i1",    0, 4'b1111, 1, 0, 2'b01, 4'b0000, 0);
        add("rot_g2",    0, 4'b1111, 0, 1, 2'b10, 4'b0100, 0);
        add("rot_i2",    0, 4'b1111, 1, 0, 2'b10, 4'b0000, 0);
        add("rot_g3",    0, 4'b1111, 0, 1, 2'b11, 4'b1000, 0);
        add("rot_i3",    0, 4'b1111, 1, 0, 2'b11, 4'b0000, 0);
        add("rot_g0b",   0, 4'b1111, 0, 1, 2'b00, 4'b0001, 0);
        add("rot_drop",  0, 4'b0000, 0, 0, 2'b00, 4'b0000, 0);
        add("hold_g2",   0, 4'b0100, 0, 1, 2'b10, 4'b0100, 0);
        add("hold_keep", 0, 4'b1111, 0, 1, 2'b10, 4'b0100, 0);
        add("hold_drop", 0, 4'b1011, 0, 0, 2'b10, 4'b0000, 0);
        add("next_g3",   0, 4'b1011, 0, 1, 2'b11, 4'b1000, 0);
        add("mid_rst",   1, 4'b1011, 0, 0, 2'b00, 4'b0000, 0);
        add("rst_win0",  0, 4'b1111, 0, 1, 2'b00, 4'b0001, 0);
        add("end_drop",  0, 4'b0000, 0, 0, 2'b00, 4'b0000, 0);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; req = tbl[i].req; done = tbl[i].done;
            @(negedge clk);
            chk(tbl[i].name, {v15, s1_15, s0_15, g15, to15},
                {tbl[i].vld, tbl[i].sel, tbl[i].gnt, tbl[i].to});
        end

        // Timeout: MAX_HOLD=3, single continuous requester.
        do_reset();
        req = 4'b0010;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            eg = (c == 4) ? 4'b0000 : 4'b0010;
            et = (c == 4);
            chk($sformatf("tmo_c%0d", c), {v3, g3, to3}, {(c != 4), eg, et});
        end

        // Fairness: MAX_HOLD=3, two continuous requesters alternate.
        do_reset();
        req = 4'b0011;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if ((c - 1) % 4 == 3) begin
                eg = 4'b0000; et = 1'b1;
            end else begin
                eg = 4'b0001 << (((c - 1) / 4) % 2); et = 1'b0;
            end
            chk($sformatf("fair_c%0d", c), {g3, to3}, {eg, et});
        end

        // Collision: MAX_HOLD=2, done arrives exactly when the hold limit is reached.
        do_reset();
        req = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        chk("col_held", {v2, g2}, {1'b1, 4'b0001});
        done = 1'b1;
        @(negedge clk);
        chk("col_rel", {v2, g2, to2}, {1'b0, 4'b0000, 1'b0});
        done = 1'b0;

        // Default MAX_HOLD=15 times out after 15 cycles; MAX_HOLD=0 never does.
        do_reset();
        req = 4'b1000;
        vcnt = 0; seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (v15) vcnt++;
            if (to15) seen = 1;
            if (to0) chk("nohold_to", {31'd0, to0}, 32'd0);
        end
        chk("hold15_cnt", vcnt, 15);
        chk("hold15_to", {31'd0, seen}, 32'd1);
        chk("nohold_vld", {v0, g0}, {1'b1, 4'b1000});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
